// File: rtl/lbp_pkg.sv
// lbp_pkg: pixel type, window FSM states and neighbour indices shared
// by the LBP window generator and the interpolation stage.
package lbp_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } win_state_t;

  // Diagonal quads for interpolation: mid, two adjacent axials, corner.
  localparam int NB_MID  = 0;
  localparam int NB_S0   = 1;
  localparam int NB_S90  = 2;
  localparam int NB_S180 = 3;
  localparam int NB_S270 = 4;
  localparam int NB_P45  = 5;
  localparam int NB_P135 = 6;
  localparam int NB_P225 = 7;
  localparam int NB_P315 = 8;
  localparam int NB_N    = 9;

  // Tap row: 0 = r-1, 1 = r, 2 = r+1.
  function automatic logic [1:0] nb_row(input int idx);
    unique case (idx)
      NB_S90, NB_P45, NB_P135:   nb_row = 2'd0;
      NB_S270, NB_P225, NB_P315: nb_row = 2'd2;
      default:                   nb_row = 2'd1;
    endcase
  endfunction

  // Tap column: 0 = c-1, 1 = c, 2 = c+1.
  function automatic logic [1:0] nb_col(input int idx);
    unique case (idx)
      NB_S180, NB_P135, NB_P225: nb_col = 2'd0;
      NB_S0, NB_P45, NB_P315:    nb_col = 2'd2;
      default:                   nb_col = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/lbp_line_buffer.sv
// lbp_line_buffer: DEPTH-deep pixel delay line, advancing only on en.
// dout is the sample written DEPTH enables ago.
module lbp_line_buffer
  import lbp_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

  pix_t          mem [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (en) mem[ptr_q] <= din;
  end

  assign dout = mem[ptr_q];

endmodule

// File: rtl/lbp_window_gen.sv
// lbp_window_gen: streaming 3x3 window generator with border padding.
// Define LBP_WINDOW_REPLICATE_EN for edge replicate instead of zero pad.
module lbp_window_gen
  import lbp_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_i,
  input  logic             valid_i,
  output logic [PIX_W-1:0] mid_o,
  output logic [PIX_W-1:0] S_0_o,
  output logic [PIX_W-1:0] S_90_o,
  output logic [PIX_W-1:0] S_180_o,
  output logic [PIX_W-1:0] S_270_o,
  output logic [PIX_W-1:0] P_45_o,
  output logic [PIX_W-1:0] P_135_o,
  output logic [PIX_W-1:0] P_225_o,
  output logic [PIX_W-1:0] P_315_o,
  output logic             valid_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  win_state_t      state_q, state_d;
  logic [CW-1:0]   in_col_q, in_col_d;
  logic [RW-1:0]   in_row_q, in_row_d;
  logic [CW-1:0]   cen_col_q, cen_col_d;
  logic [RW-1:0]   cen_row_q, cen_row_d;
  pix_t [1:0]      top_q, top_d;
  pix_t [1:0]      mid_q, mid_d;
  pix_t [1:0]      bot_q, bot_d;
  pix_t [NB_N-1:0] win_q, win_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic            accept, emit, shift;
  logic            fill_end, in_last, cen_last;
  logic            at_top, at_bot, at_left, at_right;
  pix_t            pix_in, lb1_out, lb2_out;
  pix_t            tap [3][3];
  pix_t [NB_N-1:0] nb;

  assign fill_end = (in_row_q == RW'(1)) && (in_col_q == CW'(1));
  assign in_last  = (in_row_q == ROW_MAX) && (in_col_q == COL_MAX);
  assign cen_last = (cen_row_q == ROW_MAX) && (cen_col_q == COL_MAX);
  assign at_top   = (cen_row_q == '0);
  assign at_bot   = (cen_row_q == ROW_MAX);
  assign at_left  = (cen_col_q == '0);
  assign at_right = (cen_col_q == COL_MAX);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          accept  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (valid_i) begin
          accept = 1'b1;
          if (fill_end) begin
            emit    = 1'b1;
            state_d = in_last ? FLUSH : RUN;
          end
        end
      end
      RUN: begin
        if (valid_i) begin
          accept = 1'b1;
          emit   = 1'b1;
          if (in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        emit = 1'b1;
        if (cen_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FLUSH pushes dummy pixels through to drain the last line.
  assign shift  = accept || (state_q == FLUSH);
  assign pix_in = (state_q == FLUSH) ? '0 : pixel_i;

  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    cen_col_d = cen_col_q;
    cen_row_d = cen_row_q;
    if (accept) begin
      if (in_col_q == COL_MAX) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_MAX) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
    if (emit) begin
      if (cen_col_q == COL_MAX) begin
        cen_col_d = '0;
        cen_row_d = (cen_row_q == ROW_MAX) ? '0 : cen_row_q + RW'(1);
      end else begin
        cen_col_d = cen_col_q + CW'(1);
      end
    end
  end

  lbp_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift),
    .din  (pix_in),
    .dout (lb1_out)
  );

  lbp_line_buffer #(.DEPTH(WIDTH)) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_comb begin
    top_d = top_q;
    mid_d = mid_q;
    bot_d = bot_q;
    if (shift) begin
      top_d = {top_q[0], lb2_out};
      mid_d = {mid_q[0], lb1_out};
      bot_d = {bot_q[0], pix_in};
    end
  end

  // Window is taken from the post-shift view so it can be registered.
  always_comb begin
    tap[0][0] = top_q[1];
    tap[0][1] = top_q[0];
    tap[0][2] = lb2_out;
    tap[1][0] = mid_q[1];
    tap[1][1] = mid_q[0];
    tap[1][2] = lb1_out;
    tap[2][0] = bot_q[1];
    tap[2][1] = bot_q[0];
    tap[2][2] = pix_in;
  end

  always_comb begin
    logic [1:0] rs;
    logic [1:0] cs;
    rs = '0;
    cs = '0;
    nb = '0;
    for (int i = 0; i < NB_N; i++) begin
      rs = nb_row(i);
      cs = nb_col(i);
`ifdef LBP_WINDOW_REPLICATE_EN
      if ((rs == 2'd0 && at_top) || (rs == 2'd2 && at_bot))
        rs = 2'd1;
      if ((cs == 2'd0 && at_left) || (cs == 2'd2 && at_right))
        cs = 2'd1;
      nb[i] = tap[rs][cs];
`else
      if (!((rs == 2'd0 && at_top) || (rs == 2'd2 && at_bot) ||
            (cs == 2'd0 && at_left) || (cs == 2'd2 && at_right)))
        nb[i] = tap[rs][cs];
`endif
    end
  end

  always_comb begin
    win_d   = emit ? nb : win_q;
    valid_d = emit;
    done_d  = emit && cen_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_col_q  <= '0;
      in_row_q  <= '0;
      cen_col_q <= '0;
      cen_row_q <= '0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      cen_col_q <= cen_col_d;
      cen_row_q <= cen_row_d;
      top_q     <= top_d;
      mid_q     <= mid_d;
      bot_q     <= bot_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign mid_o   = win_q[NB_MID];
  assign S_0_o   = win_q[NB_S0];
  assign S_90_o  = win_q[NB_S90];
  assign S_180_o = win_q[NB_S180];
  assign S_270_o = win_q[NB_S270];
  assign P_45_o  = win_q[NB_P45];
  assign P_135_o = win_q[NB_P135];
  assign P_225_o = win_q[NB_P225];
  assign P_315_o = win_q[NB_P315];
  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_lbp_window_gen.sv
// tb_lbp_window_gen: scoreboard bench for lbp_window_gen at 4x3.
// Build with LBP_WINDOW_REPLICATE_EN to check the edge-replicate variant.
module tb_lbp_window_gen;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  // Packed {P315,P225,P135,P45,S270,S180,S90,S0,mid}
  localparam logic [71:0] SPOT_C6 = 72'h0B_09_01_03_0A_05_02_07_06;
`ifdef LBP_WINDOW_REPLICATE_EN
  localparam logic [71:0] SPOT_C1  = 72'h06_05_01_02_05_01_01_02_01;
  localparam logic [71:0] SPOT_C12 = 72'h0C_0B_07_08_0C_0B_08_0C_0C;
`else
  localparam logic [71:0] SPOT_C1  = 72'h06_00_00_00_05_00_00_02_01;
  localparam logic [71:0] SPOT_C12 = 72'h00_00_07_00_00_0B_08_00_0C;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pixel_i = '0;
  logic       valid_i = 1'b0;
  logic [7:0] mid_o, S_0_o, S_90_o, S_180_o, S_270_o;
  logic [7:0] P_45_o, P_135_o, P_225_o, P_315_o;
  logic       valid_o, done_o;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int stray_done = 0;

  typedef struct {
    logic [71:0] w;
    logic        d;
    int          c;
  } obs_t;

  obs_t        obs_q[$];
  logic [71:0] exp_q[$];

  wire [71:0] win_w = {P_315_o, P_225_o, P_135_o, P_45_o, S_270_o,
                       S_180_o, S_90_o, S_0_o, mid_o};

  lbp_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .pixel_i (pixel_i),
    .valid_i (valid_i),
    .mid_o   (mid_o),
    .S_0_o   (S_0_o),
    .S_90_o  (S_90_o),
    .S_180_o (S_180_o),
    .S_270_o (S_270_o),
    .P_45_o  (P_45_o),
    .P_135_o (P_135_o),
    .P_225_o (P_225_o),
    .P_315_o (P_315_o),
    .valid_o (valid_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) obs_q.push_back('{win_w, done_o, cyc});
    if (done_o && !valid_o) stray_done++;
  end

  function automatic logic [71:0] model(input int base, input int k);
    int dr[9] = '{0, 0, -1, 0, 1, -1, -1, 1, 1};
    int dc[9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    logic [71:0] w;
    int r, c, rr, cc;
    w = '0;
    r = k / W;
    c = k % W;
    for (int i = 0; i < 9; i++) begin
      rr = r + dr[i];
      cc = c + dc[i];
`ifdef LBP_WINDOW_REPLICATE_EN
      if (rr < 0) rr = 0;
      if (rr > H - 1) rr = H - 1;
      if (cc < 0) cc = 0;
      if (cc > W - 1) cc = W - 1;
      w[i*8 +: 8] = 8'(base + rr * W + cc);
`else
      if (rr >= 0 && rr < H && cc >= 0 && cc < W)
        w[i*8 +: 8] = 8'(base + rr * W + cc);
`endif
    end
    return w;
  endfunction

  // Pixel values are base..base+N-1; optional junk held on valid_i in FLUSH.
  task automatic drive_frame(input int base, input int gap,
                             input bit junk, output int first_acc,
                             output int last_acc);
    first_acc = 0;
    last_acc = 0;
    for (int i = 0; i < N; i++) begin
      valid_i = 1'b1;
      pixel_i = 8'(base + i);
      if (i == W + 1) first_acc = cyc;
      if (i == N - 1) last_acc = cyc;
      if (i >= W + 1) exp_q.push_back(model(base, i - W - 1));
      @(posedge clk); #1;
      if (i < N - 1) begin
        repeat (gap) begin
          valid_i = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    for (int k = N - W - 1; k < N; k++) exp_q.push_back(model(base, k));
    if (junk) begin
      valid_i = 1'b1;
      pixel_i = 8'hEE;
      repeat (W + 1) begin
        @(posedge clk); #1;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({win_w, valid_o, done_o} !== '0)
      $display("FAIL reset_hold: got %h/%b/%b want all 0",
               win_w, valid_o, done_o);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({win_w, valid_o, done_o} !== '0)
      $display("FAIL reset_release: got %h/%b/%b want all 0",
               win_w, valid_o, done_o);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_continuous;
    int fa, la;
    bit seen;
    obs_t o, w0, w5, wl;
    logic [71:0] e;
    obs_q.delete();
    exp_q.delete();
    drive_frame(1, 0, 1'b1, fa, la);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    #1;
    n_checks++;
    if (!seen) $display("FAIL cont_done_timeout: got none want done_o");
    else n_pass++;
    n_checks++;
    if (obs_q.size() != N)
      $display("FAIL cont_count: got %0d want %0d", obs_q.size(), N);
    else n_pass++;
    w0 = '{'0, 1'b0, 0};
    w5 = w0;
    wl = w0;
    for (int k = 0; k < N && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.w !== e) $display("FAIL cont_win%0d: got %h want %h", k, o.w, e);
      else n_pass++;
      n_checks++;
      if (o.d !== (k == N - 1))
        $display("FAIL cont_done%0d: got %b want %b", k, o.d, k == N - 1);
      else n_pass++;
      if (k == 0) w0 = o;
      if (k == 5) w5 = o;
      if (k == N - 1) wl = o;
    end
    n_checks++;
    if (w0.w !== SPOT_C1) $display("FAIL spot_c1: got %h want %h", w0.w, SPOT_C1);
    else n_pass++;
    n_checks++;
    if (w5.w !== SPOT_C6) $display("FAIL spot_c6: got %h want %h", w5.w, SPOT_C6);
    else n_pass++;
    n_checks++;
    if (wl.w !== SPOT_C12) $display("FAIL spot_c12: got %h want %h", wl.w, SPOT_C12);
    else n_pass++;
    n_checks++;
    if (w0.c - fa != 1)
      $display("FAIL cont_first_lat: got %0d want 1", w0.c - fa);
    else n_pass++;
    n_checks++;
    if (wl.c - la != W + 2)
      $display("FAIL cont_done_lat: got %0d want %0d", wl.c - la, W + 2);
    else n_pass++;
  endtask

  task automatic test_gapped;
    int fa, la;
    bit seen;
    obs_t o, wl;
    logic [71:0] e;
    obs_q.delete();
    exp_q.delete();
    drive_frame(1, 1, 1'b0, fa, la);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    #1;
    n_checks++;
    if (!seen) $display("FAIL gap_done_timeout: got none want done_o");
    else n_pass++;
    n_checks++;
    if (obs_q.size() != N)
      $display("FAIL gap_count: got %0d want %0d", obs_q.size(), N);
    else n_pass++;
    wl = '{'0, 1'b0, 0};
    for (int k = 0; k < N && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.w !== e) $display("FAIL gap_win%0d: got %h want %h", k, o.w, e);
      else n_pass++;
      if (o.d) wl = o;
    end
    n_checks++;
    if (wl.c - la != W + 2)
      $display("FAIL gap_done_lat: got %0d want %0d", wl.c - la, W + 2);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int fa, la;
    bit seen, stale;
    obs_t o;
    logic [71:0] e;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      pixel_i = 8'(i + 1);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({win_w, valid_o, done_o} !== '0)
      $display("FAIL midrst_out: got %h/%b/%b want all 0",
               win_w, valid_o, done_o);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    drive_frame(101, 0, 1'b0, fa, la);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    #1;
    n_checks++;
    if (!seen) $display("FAIL midrst_done_timeout: got none want done_o");
    else n_pass++;
    n_checks++;
    if (obs_q.size() != N)
      $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), N);
    else n_pass++;
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0].w[7:0] !== 8'd101)
      $display("FAIL midrst_first_mid: got %h want 65",
               obs_q.size() ? obs_q[0].w[7:0] : 8'hxx);
    else n_pass++;
    stale = 0;
    for (int k = 0; k < N && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      for (int b = 0; b < 9; b++)
        if (o.w[b*8 +: 8] >= 8'd1 && o.w[b*8 +: 8] <= 8'd12) stale = 1;
      n_checks++;
      if (o.w !== e) $display("FAIL midrst_win%0d: got %h want %h", k, o.w, e);
      else n_pass++;
    end
    n_checks++;
    if (stale) $display("FAIL midrst_stale: got old-frame value want none");
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int fa, la, la2, dones;
    bit seen;
    obs_t o;
    logic [71:0] e;
    obs_q.delete();
    exp_q.delete();
    drive_frame(1, 0, 1'b0, fa, la);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL b2b_done1_timeout: got none want done_o");
    else n_pass++;
    @(posedge clk); #1;
    drive_frame(201, 0, 1'b0, fa, la2);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    #1;
    n_checks++;
    if (!seen) $display("FAIL b2b_done2_timeout: got none want done_o");
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 2 * N)
      $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 2 * N);
    else n_pass++;
    dones = 0;
    for (int k = 0; k < 2 * N && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.d) dones++;
      n_checks++;
      if (o.w !== e) $display("FAIL b2b_win%0d: got %h want %h", k, o.w, e);
      else n_pass++;
    end
    n_checks++;
    if (dones != 2) $display("FAIL b2b_dones: got %0d want 2", dones);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_mid_reset();
    test_back_to_back();
    n_checks++;
    if (stray_done != 0)
      $display("FAIL stray_done: got %0d want 0", stray_done);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lbp_window_gen.md
# lbp_window_gen

Streaming 3x3 neighbourhood generator feeding the interpolation stage of the LBP pipeline. Accepts an 8-bit raster pixel stream with a valid qualifier and buffers two image lines. For every pixel it emits the centre plus its 8 neighbours, with border handling. After the last input pixel it flushes the final line internally and pulses `done_o` with the final window.

## Interface
- `WIDTH`, 640: image columns, ≥2
- `HEIGHT`, 480: image rows, ≥2
- `clk` input 1: rising-edge clock
- `rst` input 1: asynchronous, active-high reset
- `pixel_i` input 8: raster-order pixel, qualified by `valid_i`
- `valid_i` input 1: pixel accepted this cycle; no backpressure
- `mid_o` output 8: centre (r,c)
- `S_0_o` output 8: (r,c+1)
- `S_90_o` output 8: (r-1,c)
- `S_180_o` output 8: (r,c-1)
- `S_270_o` output 8: (r+1,c)
- `P_45_o` output 8: (r-1,c+1)
- `P_135_o` output 8: (r-1,c-1)
- `P_225_o` output 8: (r+1,c-1)
- `P_315_o` output 8: (r+1,c+1)
- `valid_o` output 1: window outputs valid this cycle
- `done_o` output 1: one-cycle pulse with the frame's last window; drives interpolation `done_i`
- Top-level wiring into interpolation, each diagonal fed its bilinear quad: `S_45_i_1..4` = mid, S_0, S_90, P_45. The other diagonals use the same order: mid, then the two adjacent axial samples, then the corner.

## Operation
- States: IDLE, FILL, RUN, FLUSH.
- IDLE: first `valid_i` → FILL; that pixel is index 0.
- FILL: accepted pixels advance the index. Acceptance of index W+1 → RUN, and emits centre 0.
- RUN: acceptance of pixel k+W+1 emits centre k. After acceptance of index N-1 (N = WIDTH·HEIGHT) → FLUSH.
- FLUSH: emits the remaining W+1 windows, centres N-W-1..N-1, one per cycle regardless of `valid_i`. `valid_i` is ignored in FLUSH. The final window asserts `done_o`; the next state is IDLE.
- Windows are emitted in raster order of the centre; exactly N windows per frame.
- Line storage: two W-deep line buffers plus three 3-tap shift registers.
- Row and column counters track the centre position. A neighbour outside the frame is the padding value, never stale buffer contents.
- Gaps in `valid_i` stall emission in FILL and RUN; outputs hold their last values while `valid_o`=0.
- Reset (any time, including mid-frame): state IDLE, counters 0, all outputs 0, `valid_o`=0, `done_o`=0. Line-buffer contents are not reset. The next frame starts clean.
- Unsigned 8-bit data, no arithmetic on pixels. Counters are sized `$clog2(WIDTH)` and `$clog2(HEIGHT)`. The column counter wraps at WIDTH-1 to 0 and increments the row.

## Timing
- All outputs are registered.
- Window k is visible on the cycle after pixel k+W+1 is accepted.
- With a continuous stream, FLUSH emits on W+1 consecutive cycles starting one cycle after window N-W-2.
- `done_o` asserts W+2 cycles after the last pixel is accepted, coincident with `valid_o`.
- Back-to-back frames: `valid_i` is accepted again from the cycle after `done_o` (IDLE).

## Configuration
- `LBP_WINDOW_REPLICATE_EN` defined: out-of-frame neighbours take the nearest in-frame pixel (edge replicate), clamped separately in row and column.
- Not defined: out-of-frame neighbours are 0 (zero padding).

## Structure
- Shared package `lbp_pkg`:
  - `PIX_W` = 8, the pixel typedef `pix_t`
  - state enum `win_state_t`
  - neighbour-index constants, shared with interpolation
- One sub-module, `lbp_line_buffer`: W-deep 8-bit delay line with enable, instantiated twice.

## Test plan
- Zero-pad, WIDTH=4, HEIGHT=3, pixels 1..12 continuous → 12 `valid_o` pulses. Centre 1 gives S_0=2, S_270=5, P_315=6, all others 0. `done_o` coincides with centre 12.
- Same frame, centre 6 → S_0=7, S_90=2, S_180=5, S_270=10, P_45=3, P_135=1, P_225=9, P_315=11.
- Replicate build, same frame, centre 1 → S_90=1, S_180=1, P_135=1, P_45=2, P_225=5. Centre 12 → S_0=12, S_270=12, P_315=12.
- `valid_i` asserted every other cycle → identical window sequence; `done_o` exactly W+2 cycles after the last accepted pixel.
- `rst` pulsed after 6 pixels, then a full new frame 101..112 → first window mid=101 with all upper/left neighbours padded; no value ≤12 appears.
- Two frames back-to-back, second frame starting the cycle after `done_o` → 24 windows total, two `done_o` pulses.
